// File: rtl/viterbi_ctrl_pkg.sv
// Shared types for the Viterbi link frame sequencer: FSM states, channel
// flip masks and the reference-bit entry carried alongside the pipeline.
package viterbi_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, PAYLOAD, TAIL, DRAIN, DONE} state_t;

  typedef logic [1:0] sym_t;

  localparam sym_t FLIP_NONE = 2'b00;
  localparam sym_t FLIP_BOTH = 2'b11;

  typedef struct packed {
    logic valid;
    logic score;
    logic data;
  } ref_entry_t;

endpackage

// File: rtl/viterbi_ref_delay.sv
// Reference delay line: shifts one ref_entry_t per cycle so the sent bit
// emerges in the same cycle as the matching decoder output.
module viterbi_ref_delay
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  ref_entry_t line [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder -> channel -> Viterbi decoder link:
// payload/tail sequencing, flip scheduling and per-frame error scoring.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned TAIL       = 2,
  parameter int unsigned DEC_LAT    = 24,
  parameter int unsigned ERR_PERIOD = 16,
  parameter int unsigned ERR_BURST  = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             inj_en_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic             bit_ready_o,
  output logic             enc_enable_o,
  output logic             enc_d_o,
  output logic [1:0]       chan_flip_o,
  output logic             dec_enable_o,
  input  logic             dec_bit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_bits_o,
  output logic [CNT_W-1:0] inj_ct_o
);

  localparam int unsigned DEPTH = DEC_LAT + 2;
  localparam int unsigned MAX_A = (FRAME_LEN > DEPTH) ? FRAME_LEN : DEPTH;
  localparam int unsigned MAX_N = (MAX_A > TAIL) ? MAX_A : TAIL;
  localparam int unsigned CW    = $clog2(MAX_N + 1);
  localparam int unsigned PW    = $clog2(ERR_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   sym_mod_q;
  logic            inj_q;
  logic            en_d1;
  logic            flip_now;
  ref_entry_t      push_e;
  ref_entry_t      tail_e;
  logic [2:0]      tail_bits;

  always_comb begin
    state_d      = state_q;
    bit_ready_o  = 1'b0;
    enc_enable_o = 1'b0;
    enc_d_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    push_e       = '0;
    case (state_q)
      IDLE: if (start_i) state_d = PAYLOAD;
      PAYLOAD: begin
        busy_o      = 1'b1;
        bit_ready_o = 1'b1;
        if (bit_valid_i) begin
          enc_enable_o = 1'b1;
          enc_d_o      = bit_i;
          push_e       = '{valid: 1'b1, score: 1'b1, data: bit_i};
          if (cnt_q == CW'(FRAME_LEN - 1))
            state_d = (TAIL == 0) ? DRAIN : viterbi_ctrl_pkg::TAIL;
        end
      end
      viterbi_ctrl_pkg::TAIL: begin
        busy_o       = 1'b1;
        enc_enable_o = 1'b1;
        push_e       = '{valid: 1'b1, score: 1'b0, data: 1'b0};
        if (cnt_q == CW'(TAIL - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        // Last enabled entry leaves the delay line after DEPTH drain cycles.
        if (cnt_q == CW'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flip_now = enc_enable_o && inj_q && (sym_mod_q < PW'(ERR_BURST));
  assign tail_e   = tail_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      sym_mod_q    <= '0;
      inj_q        <= 1'b0;
      en_d1        <= 1'b0;
      dec_enable_o <= 1'b0;
      chan_flip_o  <= FLIP_NONE;
      err_bits_o   <= '0;
      inj_ct_o     <= '0;
    end else begin
      en_d1        <= enc_enable_o;
      dec_enable_o <= en_d1;
      chan_flip_o  <= flip_now ? FLIP_BOTH : FLIP_NONE;

      if (state_d != state_q)
        cnt_q <= '0;
      else if (enc_enable_o || state_q == DRAIN)
        cnt_q <= cnt_q + CW'(1);

      if (enc_enable_o)
        sym_mod_q <= (sym_mod_q == PW'(ERR_PERIOD - 1)) ? '0 : sym_mod_q + PW'(1);

      if (flip_now)
        inj_ct_o <= (inj_ct_o >= CNT_MAX - CNT_W'(1)) ? CNT_MAX : inj_ct_o + CNT_W'(2);

      if (tail_e.valid && tail_e.score && (tail_e.data != dec_bit_i) && (err_bits_o != CNT_MAX))
        err_bits_o <= err_bits_o + CNT_W'(1);

      if (state_q == IDLE && start_i) begin
        inj_q      <= inj_en_i;
        sym_mod_q  <= '0;
        err_bits_o <= '0;
        inj_ct_o   <= '0;
      end
    end
  end

  viterbi_ref_delay #(.DEPTH(DEPTH)) u_ref (
    .clk  (clk),
    .rst  (rst),
    .din  (push_e),
    .dout (tail_bits)
  );

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Scoreboard bench: two sequencers (burst 1 and burst 2) share stimulus; a
// bench-side decoder echoes sent bits DEC_LAT after dec_enable_o.
module tb_viterbi_frame_ctrl;

  localparam int FL = 64;
  localparam int DL = 24;
  localparam logic [127:0] M_B1 = (128'd1 << 0) | (128'd1 << 16) | (128'd1 << 32) |
                                  (128'd1 << 48) | (128'd1 << 64);
  localparam logic [127:0] M_B2 = M_B1 | (128'd1 << 1) | (128'd1 << 17) | (128'd1 << 33) |
                                  (128'd1 << 49) | (128'd1 << 65);

  logic clk = 1'b0, rst = 1'b0;
  logic start_i = 1'b0, inj_en_i = 1'b0, bit_valid_i = 1'b0, bit_i = 1'b0;
  logic dec_bit1 = 1'b0, dec_bit2 = 1'b0;
  logic rdy1, en1, d1, den1, busy1, done1;
  logic rdy2, en2, d2, den2, busy2, done2;
  logic [1:0]  fl1, fl2;
  logic [15:0] err1, inj1, err2, inj2;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(64), .TAIL(2), .DEC_LAT(24), .ERR_PERIOD(16),
                       .ERR_BURST(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .inj_en_i(inj_en_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(rdy1),
    .enc_enable_o(en1), .enc_d_o(d1), .chan_flip_o(fl1), .dec_enable_o(den1),
    .dec_bit_i(dec_bit1), .busy_o(busy1), .done_o(done1),
    .err_bits_o(err1), .inj_ct_o(inj1));

  viterbi_frame_ctrl #(.FRAME_LEN(64), .TAIL(2), .DEC_LAT(24), .ERR_PERIOD(16),
                       .ERR_BURST(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start_i), .inj_en_i(inj_en_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(rdy2),
    .enc_enable_o(en2), .enc_d_o(d2), .chan_flip_o(fl2), .dec_enable_o(den2),
    .dec_bit_i(dec_bit2), .busy_o(busy2), .done_o(done2),
    .err_bits_o(err2), .inj_ct_o(inj2));

  typedef struct {
    int err1, inj1, err2, inj2, encs;
    logic [127:0] m1, m2;
  } exp_t;

  exp_t exp_q[$];
  bit   enc_exp[$];
  bit   dec_src[$];
  int   checks = 0, failures = 0;
  bit   invert = 1'b0, corrupt = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_mask(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_dut1"}, longint'({rdy1, en1, d1, fl1, den1, busy1, done1, err1, inj1}), 0);
    chk({name, "_dut2"}, longint'({rdy2, en2, d2, fl2, den2, busy2, done2, err2, inj2}), 0);
  endtask

  // Monitor: cycle tallies, bench decoder, and scoreboard pop on done_o.
  int cyc = 0, enc_cnt = 0, dec_idx = 0, last_enc = 0, prev_sym = 0;
  bit prev_en = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic [127:0] m1a = '0, m2a = '0;
  bit sched1 [64];
  bit sched2 [64];

  always @(negedge clk) begin
    if (!rst) begin
      enc_cnt = 0; dec_idx = 0; prev_en = 1'b0; prev_sym = 0;
      h1 = 1'b0; h2 = 1'b0; m1a = '0; m2a = '0;
      dec_bit1 = 1'b0; dec_bit2 = 1'b0;
    end else begin
      bit b, c;
      int s;
      exp_t e;
      cyc++;
      dec_bit1 = sched1[cyc % 64];
      dec_bit2 = sched2[cyc % 64];

      chk("dec_enable1", longint'(den1), longint'(h2));
      chk("dec_enable2", longint'(den2), longint'(h2));
      h2 = h1; h1 = en1;

      if (fl1 != 2'b00) begin
        if (prev_en && fl1 == 2'b11 && prev_sym < 127) m1a[prev_sym] = 1'b1;
        else m1a[127] = 1'b1;
      end
      if (fl2 != 2'b00) begin
        if (prev_en && fl2 == 2'b11 && prev_sym < 127) m2a[prev_sym] = 1'b1;
        else m2a[127] = 1'b1;
      end
      prev_en = en1; prev_sym = enc_cnt;

      if (en1) begin
        last_enc = cyc;
        if (enc_exp.size() == 0) chk("enc_extra", 1, 0);
        else begin
          b = enc_exp.pop_front();
          chk("enc_d1", longint'(d1), longint'(b));
          chk("enc_d2", longint'(d2), longint'(b));
        end
        enc_cnt++;
      end

      if (den1) begin
        b = (dec_src.size() != 0) ? dec_src.pop_front() : 1'b0;
        c = corrupt && (dec_idx < FL) && (dec_idx % 16 == 0);
        s = (cyc + DL) % 64;
        sched1[s] = b ^ invert;
        sched2[s] = b ^ invert ^ c;
        dec_idx++;
      end

      if (done1) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_bits1", longint'(err1), e.err1);
          chk("inj_ct1", longint'(inj1), e.inj1);
          chk("err_bits2", longint'(err2), e.err2);
          chk("inj_ct2", longint'(inj2), e.inj2);
          chk("enc_count", enc_cnt, e.encs);
          chk_mask("flips1", m1a, e.m1);
          chk_mask("flips2", m2a, e.m2);
          chk("done_latency", cyc - last_enc, DL + 3);
          chk("done2_align", longint'(done2), 1);
          chk("busy_at_done", longint'(busy1), 0);
        end
        enc_cnt = 0; dec_idx = 0; m1a = '0; m2a = '0;
      end
    end
  end

  task automatic run_frame(input bit inj, input bit stall, input bit inv, input bit cor,
                           input bit poke, input int abort_at, input exp_t e);
    int acc = 0, guard = 0;
    invert = inv; corrupt = cor;
    if (abort_at < 0) exp_q.push_back(e);
    @(posedge clk); #1; start_i = 1'b1; inj_en_i = inj;
    @(posedge clk); #1; start_i = 1'b0; inj_en_i = 1'b0;
    while (acc < FL && guard < 1000) begin
      guard++;
      if (acc == abort_at) begin
        bit_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outs("abort_reset");
        enc_exp.delete(); dec_src.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        return;
      end
      bit_valid_i = stall ? (guard % 2 == 1) : 1'b1;
      bit_i       = (acc % 2 == 0);
      start_i     = poke && (acc == 10);
      if (bit_valid_i && rdy1) begin
        enc_exp.push_back(bit_i);
        dec_src.push_back(bit_i);
        acc++;
      end
      @(posedge clk); #1;
    end
    bit_valid_i = 1'b0; bit_i = 1'b0; start_i = 1'b0;
    if (acc < FL) chk("payload_timeout", acc, FL);
    repeat (2) begin enc_exp.push_back(1'b0); dec_src.push_back(1'b0); end
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    run_frame(0, 0, 0, 0, 0, -1, '{0, 0, 0, 0, 66, '0, '0});
    run_frame(1, 0, 0, 0, 0, -1, '{0, 10, 0, 20, 66, M_B1, M_B2});
    run_frame(1, 0, 0, 1, 0, -1, '{0, 10, 4, 20, 66, M_B1, M_B2});
    run_frame(0, 1, 0, 0, 0, -1, '{0, 0, 0, 0, 66, '0, '0});
    run_frame(0, 0, 0, 0, 0, 20, '{0, 0, 0, 0, 0, '0, '0});
    run_frame(0, 0, 0, 0, 0, -1, '{0, 0, 0, 0, 66, '0, '0});
    run_frame(0, 0, 1, 0, 1, -1, '{64, 0, 64, 0, 66, '0, '0});
    repeat (5) @(posedge clk);
    #1;
    chk("err_hold", longint'(err1), 64);
    chk("idle_after_done", longint'(busy1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
